electrical_phase_tracker: RTL and testbench

//  Parametrised hall+encoder electrical-angle tracker for the PMSM FOC path. Accumulates decoded encoder

---
 rtl/pmsm_phase_pkg.sv | 49 ++++
 rtl/phase_sincos_lut.sv | 76 +++++++
 rtl/electrical_phase_tracker.sv | 193 +++++++++++++++++++
 tb/tb_electrical_phase_tracker.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmsm_phase_pkg.sv
// Shared types and elaboration-time helpers for the electrical phase tracker:
// FSM states, hall decoding, sector adjacency, hall boundary placement and phase scaling.
package pmsm_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_COARSE = 3'd2,
    ST_FINE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [2:0] NO_SECTOR = 3'd7;

  // Forward rotation visits sectors 0..5 in this hall order.
  function automatic logic [2:0] hall2sector(input logic [2:0] hall);
    case (hall)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      3'b001:  return 3'd5;
      default: return NO_SECTOR;
    endcase
  endfunction

  function automatic logic [2:0] sector_next(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic is_adjacent(input logic [2:0] a, input logic [2:0] b);
    return (b == sector_next(a)) || (a == sector_next(b));
  endfunction

  // round(k*cnt_e/6) + offset, folded into [0, cnt_e-1].
  function automatic int boundary(input int k, input int cnt_e, input int offset);
    int b;
    b = (2 * k * cnt_e + 6) / 12 + offset;
    b = b % cnt_e;
    if (b < 0) b = b + cnt_e;
    return b;
  endfunction

  function automatic longint scale_k(input int cnt_e, input int phase_w);
    return ((longint'(1) <<< (phase_w + 16)) + longint'(cnt_e) - 1) / longint'(cnt_e);
  endfunction

endpackage

// File: rtl/phase_sincos_lut.sv
// Quarter-wave sine ROM with quadrant folding; two register stages from phase_in to sin/cos.
// Table contents are computed at elaboration with a fixed-point Taylor series.
module phase_sincos_lut #(
  parameter int DATA_WIDTH = 16,
  parameter int PHASE_W    = 12
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [PHASE_W-1:0]           phase_in,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic signed [DATA_WIDTH-1:0] cos_out
);

  localparam int AW = PHASE_W - 2;
  localparam int QN = 1 << AW;
  localparam int MW = DATA_WIDTH - 1;
  localparam logic [MW-1:0] FULL = '1;

  // x in Q30 radians over [0, pi/2); 8 Taylor terms keep the error far below 1 LSB.
  function automatic logic [MW-1:0] quarter_sin(input int i);
    longint x, x2, term, sum;
    x    = (longint'(i) * 64'sd1686629713) / longint'(QN);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      sum  = sum + term;
    end
    return MW'((sum * longint'(FULL) + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [MW-1:0] rom [QN];

  for (genvar i = 0; i < QN; i++) begin : g_rom
    assign rom[i] = quarter_sin(i);
  end

  logic [1:0]    quad;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_neg;
  logic [MW-1:0] mag_fwd;
  logic [MW-1:0] mag_rev;

  always_comb begin
    quad    = phase_in[PHASE_W-1 -: 2];
    idx     = phase_in[AW-1:0];
    idx_neg = ~idx + AW'(1);
    mag_fwd = rom[idx];
    mag_rev = (idx == '0) ? FULL : rom[idx_neg];
  end

  logic [MW-1:0] sin_mag;
  logic [MW-1:0] cos_mag;
  logic          sin_neg;
  logic          cos_neg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sin_mag <= '0;
      cos_mag <= '0;
      sin_neg <= 1'b0;
      cos_neg <= 1'b0;
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      sin_mag <= quad[0] ? mag_rev : mag_fwd;
      sin_neg <= quad[1];
      cos_mag <= quad[0] ? mag_fwd : mag_rev;
      cos_neg <= quad[1] ^ quad[0];
      sin_out <= sin_neg ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
      cos_out <= cos_neg ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
    end
  end

endmodule

// File: rtl/electrical_phase_tracker.sv
// Hall + encoder electrical angle tracker: hall sync and illegal-code timer, sequencing FSM,
// snapping angle counter, phase scaler and sin/cos LUT.
//
// state     | meaning
// IDLE      | waiting for a forecast pulse with a legal hall code
// INIT      | one cycle: load counter to mid-sector of the current hall sector
// COARSE    | counting pulses, first adjacent hall edge snaps and aligns
// FINE      | counting pulses, hall edges re-snap only when error exceeds tolerance
// FAULT     | angle frozen until re-initialised
module electrical_phase_tracker
  import pmsm_phase_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ENC_CPR     = 8192,
  parameter int POLE_PAIRS  = 4,
  parameter int PHASE_W     = 12,
  parameter int HALL_OFFSET = 0,
  parameter int SNAP_TOL    = 8,
  parameter int FAULT_CYC   = 1024
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         electrical_rotation_phase_forecast_enable,
  input  logic                         incremental_encoder_decode_in,
  input  logic                         rotate_direction_in,
  input  logic                         hall_u_in,
  input  logic                         hall_v_in,
  input  logic                         hall_w_in,
  output logic [PHASE_W-1:0]           phase_out,
  output logic signed [DATA_WIDTH-1:0] electrical_rotation_phase_sin_out,
  output logic signed [DATA_WIDTH-1:0] electrical_rotation_phase_cos_out,
  output logic                         electrical_rotation_phase_trig_calculate_valid,
  output logic                         aligned_out,
  output logic                         hall_fault_out,
  output logic [15:0]                  correction_cnt_out
);

  localparam int CNT_E    = ENC_CPR / POLE_PAIRS;
  localparam int CW       = $clog2(CNT_E);
  localparam int KW       = PHASE_W + 17;
  localparam int PW       = CW + KW;
  localparam int HALF_SEC = (CNT_E + 6) / 12;
  localparam int IW       = $clog2(FAULT_CYC + 1);

  localparam logic [KW-1:0]        K         = KW'(scale_k(CNT_E, PHASE_W));
  localparam logic [CW-1:0]        CNT_MAX   = CW'(CNT_E - 1);
  localparam logic [IW-1:0]        ILL_LIMIT = IW'(FAULT_CYC - 1);
  localparam logic signed [CW+1:0] CNT_E_S   = (CW+2)'(CNT_E);
  localparam logic signed [CW+1:0] HALF_E_S  = (CW+2)'(CNT_E / 2);
  localparam logic signed [CW+1:0] TOL_S     = (CW+2)'(SNAP_TOL);

  function automatic logic [CW-1:0] step(input logic [CW-1:0] c, input logic rev);
    if (rev) return (c == '0) ? CNT_MAX : c - 1'b1;
    return (c == CNT_MAX) ? '0 : c + 1'b1;
  endfunction

  logic forecast;
  logic pulse;
  logic dir;
  assign forecast = electrical_rotation_phase_forecast_enable;
  assign pulse    = incremental_encoder_decode_in;
  assign dir      = rotate_direction_in;

  logic [CW-1:0] bnd [8];
  for (genvar k = 0; k < 8; k++) begin : g_bnd
    assign bnd[k] = CW'(boundary(k, CNT_E, HALL_OFFSET));
  end

  logic [2:0]    sync1, sync2;
  logic [2:0]    last_sec;
  logic [IW-1:0] ill_cnt;
  state_t        state;
  logic [CW-1:0] cnt;

  logic [2:0]           cur_sec;
  logic                 legal;
  logic                 hall_edge, fwd_edge, adj_edge, skip_edge;
  logic                 ill_trip;
  logic [CW-1:0]        target;
  logic [CW-1:0]        snap_cnt;
  logic [CW-1:0]        run_cnt;
  logic [CW:0]          init_sum;
  logic [CW-1:0]        init_cnt;
  logic signed [CW+1:0] err;
  logic                 big_err;

  always_comb begin
    cur_sec   = hall2sector(sync2);
    legal     = (cur_sec != NO_SECTOR);
    hall_edge = legal && (last_sec != NO_SECTOR) && (cur_sec != last_sec);
    fwd_edge  = hall_edge && (cur_sec == sector_next(last_sec));
    adj_edge  = hall_edge && is_adjacent(last_sec, cur_sec);
    skip_edge = hall_edge && !adj_edge;
    ill_trip  = !legal && (ill_cnt == ILL_LIMIT);
    // Reverse crossing lands one count below the boundary it just left.
    target    = fwd_edge ? bnd[cur_sec] : step(bnd[last_sec], 1'b1);
    snap_cnt  = pulse ? step(target, dir) : target;
    run_cnt   = pulse ? step(cnt, dir) : cnt;
    init_sum  = {1'b0, bnd[cur_sec]} + (CW+1)'(HALF_SEC);
    init_cnt  = (init_sum >= (CW+1)'(CNT_E)) ? CW'(init_sum - (CW+1)'(CNT_E)) : CW'(init_sum);
    err = $signed({2'b00, cnt}) - $signed({2'b00, target});
    if (err > HALF_E_S)       err = err - CNT_E_S;
    else if (err < -HALF_E_S) err = err + CNT_E_S;
    big_err = (err > TOL_S) || (err < -TOL_S);
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      last_sec <= NO_SECTOR;
      ill_cnt  <= '0;
    end else begin
      sync1 <= {hall_u_in, hall_v_in, hall_w_in};
      sync2 <= sync1;
      if (legal) begin
        last_sec <= cur_sec;
        ill_cnt  <= '0;
      end else if (ill_cnt != ILL_LIMIT) begin
        ill_cnt <= ill_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      aligned_out        <= 1'b0;
      hall_fault_out     <= 1'b0;
      correction_cnt_out <= '0;
    end else begin
      case (state)
        ST_IDLE: if (forecast && legal) state <= ST_INIT;
        ST_INIT: begin
          cnt            <= init_cnt;
          aligned_out    <= 1'b0;
          hall_fault_out <= 1'b0;
          state          <= ST_COARSE;
        end
        ST_COARSE, ST_FINE: begin
          if (ill_trip || skip_edge) begin
            state          <= ST_FAULT;
            hall_fault_out <= 1'b1;
          end else if (forecast && legal) begin
            state       <= ST_INIT;
            aligned_out <= 1'b0;
          end else if (adj_edge && state == ST_COARSE) begin
            cnt         <= snap_cnt;
            aligned_out <= 1'b1;
            state       <= ST_FINE;
          end else if (adj_edge && big_err) begin
            cnt <= snap_cnt;
            if (correction_cnt_out != 16'hFFFF) correction_cnt_out <= correction_cnt_out + 16'd1;
          end else begin
            cnt <= run_cnt;
          end
        end
        ST_FAULT: if (forecast && legal) state <= ST_INIT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  logic       active;
  logic [1:0] vpipe;
  assign active = (state == ST_COARSE) || (state == ST_FINE);

  // Valid is delayed to line up with the phase register plus the two LUT stages.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      phase_out <= '0;
      vpipe     <= '0;
      electrical_rotation_phase_trig_calculate_valid <= 1'b0;
    end else begin
      phase_out <= PHASE_W'((PW'(cnt) * PW'(K)) >> 16);
      vpipe     <= {vpipe[0], active};
      electrical_rotation_phase_trig_calculate_valid <= vpipe[1];
    end
  end

  phase_sincos_lut #(
    .DATA_WIDTH (DATA_WIDTH),
    .PHASE_W    (PHASE_W)
  ) u_lut (
    .clk      (sys_clk),
    .reset_n  (reset_n),
    .phase_in (phase_out),
    .sin_out  (electrical_rotation_phase_sin_out),
    .cos_out  (electrical_rotation_phase_cos_out)
  );

endmodule

// File: tb/tb_electrical_phase_tracker.sv
// Directed bench for electrical_phase_tracker at default parameters (CNT_E=2048, phase = 2*cnt).
module tb_electrical_phase_tracker;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               forecast = 1'b0;
  logic               pulse = 1'b0;
  logic               dir = 1'b0;
  logic [2:0]         hall = 3'b000;
  logic [11:0]        phase;
  logic signed [15:0] sin_v;
  logic signed [15:0] cos_v;
  logic               valid;
  logic               aligned;
  logic               fault;
  logic [15:0]        corr;

  int  checks = 0;
  int  failures = 0;
  real exp_r;
  real diff_r;

  electrical_phase_tracker dut (
    .sys_clk                                        (clk),
    .reset_n                                        (reset_n),
    .electrical_rotation_phase_forecast_enable      (forecast),
    .incremental_encoder_decode_in                  (pulse),
    .rotate_direction_in                            (dir),
    .hall_u_in                                      (hall[2]),
    .hall_v_in                                      (hall[1]),
    .hall_w_in                                      (hall[0]),
    .phase_out                                      (phase),
    .electrical_rotation_phase_sin_out              (sin_v),
    .electrical_rotation_phase_cos_out              (cos_v),
    .electrical_rotation_phase_trig_calculate_valid (valid),
    .aligned_out                                    (aligned),
    .hall_fault_out                                 (fault),
    .correction_cnt_out                             (corr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n, input logic d);
    dir = d;
    repeat (n) begin
      pulse = 1'b1;
      tick();
    end
    pulse = 1'b0;
    tick();
  endtask

  // Hall change reaches the FSM after the 2-flop sync; optional pulse lands on the snap cycle.
  task automatic hall_step(input logic [2:0] code, input logic with_pulse);
    hall = code;
    tick();
    tick();
    pulse = with_pulse;
    tick();
    pulse = 1'b0;
    tick();
  endtask

  task automatic do_forecast();
    forecast = 1'b1;
    tick();
    forecast = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hall = (i % 2 == 0) ? 3'b101 : 3'b100;
      pulse = 1'b1;
      forecast = 1'b1;
      tick();
    end
    pulse = 1'b0;
    forecast = 1'b0;
    checks++;
    if (phase !== 12'd0 || sin_v !== 16'sd0 || cos_v !== 16'sd0) begin
      failures++;
      $display("FAIL reset_data phase=%0d sin=%0d cos=%0d required 0/0/0", phase, sin_v, cos_v);
    end
    checks++;
    if ({valid, aligned, fault} !== 3'b000 || corr !== 16'd0) begin
      failures++;
      $display("FAIL reset_flags valid/aligned/fault=%b corr=%0d required 000/0", {valid, aligned, fault}, corr);
    end
    reset_n = 1'b1;
    hall = 3'b101;
    tick();
    tick();
    tick();
    pulses(10, 1'b0);
    checks++;
    if (phase !== 12'd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_pulses phase=%0d valid=%b required 0/0", phase, valid);
    end
  endtask

  task automatic test_init();
    do_forecast();
    checks++;
    if (phase !== 12'd342 || aligned !== 1'b0) begin
      failures++;
      $display("FAIL init_phase phase=%0d aligned=%b required 342/0", phase, aligned);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL init_valid_early valid=%b required 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL init_valid_2cyc valid=%b required 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL init_valid_3cyc valid=%b required 1", valid);
    end
    // 342/4096 of a turn is 30.06 degrees.
    checks++;
    exp_r = 32767.0 * $sin(6.283185307179586 * 342.0 / 4096.0);
    diff_r = real'(sin_v) - exp_r;
    if (diff_r > 2.0 || diff_r < -2.0) begin
      failures++;
      $display("FAIL init_sin got=%0d required=%0f +/-2", sin_v, exp_r);
    end
    checks++;
    exp_r = 32767.0 * $cos(6.283185307179586 * 342.0 / 4096.0);
    diff_r = real'(cos_v) - exp_r;
    if (diff_r > 2.0 || diff_r < -2.0) begin
      failures++;
      $display("FAIL init_cos got=%0d required=%0f +/-2", cos_v, exp_r);
    end
  endtask

  task automatic test_snap();
    pulses(100, 1'b0);
    checks++;
    if (phase !== 12'd542) begin
      failures++;
      $display("FAIL coarse_count phase=%0d required 542", phase);
    end
    hall_step(3'b100, 1'b0);
    checks++;
    if (phase !== 12'd682 || aligned !== 1'b1 || corr !== 16'd0) begin
      failures++;
      $display("FAIL coarse_snap phase=%0d aligned=%b corr=%0d required 682/1/0", phase, aligned, corr);
    end
    pulses(339, 1'b0);
    hall_step(3'b110, 1'b0);
    checks++;
    if (phase !== 12'd1360 || corr !== 16'd0) begin
      failures++;
      $display("FAIL fine_in_tol phase=%0d corr=%0d required 1360/0", phase, corr);
    end
    hall_step(3'b100, 1'b0);
    pulses(20, 1'b1);
    checks++;
    if (phase !== 12'd1320) begin
      failures++;
      $display("FAIL fine_rev_count phase=%0d required 1320", phase);
    end
    hall_step(3'b110, 1'b0);
    checks++;
    if (phase !== 12'd1366 || corr !== 16'd1) begin
      failures++;
      $display("FAIL fine_resnap phase=%0d corr=%0d required 1366/1", phase, corr);
    end
  endtask

  task automatic test_wrap();
    pulses(1364, 1'b0);
    checks++;
    if (phase !== 12'd4094) begin
      failures++;
      $display("FAIL wrap_top phase=%0d required 4094", phase);
    end
    tick();
    tick();
    checks++;
    exp_r = 32767.0 * $sin(6.283185307179586 * 4094.0 / 4096.0);
    diff_r = real'(sin_v) - exp_r;
    if (diff_r > 2.0 || diff_r < -2.0) begin
      failures++;
      $display("FAIL wrap_top_sin got=%0d required=%0f +/-2", sin_v, exp_r);
    end
    pulses(1, 1'b0);
    checks++;
    if (phase !== 12'd0) begin
      failures++;
      $display("FAIL wrap_fwd phase=%0d required 0", phase);
    end
    tick();
    tick();
    checks++;
    if (sin_v > 16'sd2 || sin_v < -16'sd2 || cos_v < 16'sd32765) begin
      failures++;
      $display("FAIL wrap_zero_trig sin=%0d cos=%0d required ~0/~32767", sin_v, cos_v);
    end
    pulses(1, 1'b1);
    checks++;
    if (phase !== 12'd4094) begin
      failures++;
      $display("FAIL wrap_rev phase=%0d required 4094", phase);
    end
    tick();
    tick();
    checks++;
    exp_r = 32767.0 * $cos(6.283185307179586 * 4094.0 / 4096.0);
    diff_r = real'(cos_v) - exp_r;
    if (diff_r > 2.0 || diff_r < -2.0 || sin_v >= 16'sd0) begin
      failures++;
      $display("FAIL wrap_rev_trig sin=%0d cos=%0d required negative/%0f", sin_v, cos_v, exp_r);
    end
  endtask

  task automatic test_reverse();
    hall_step(3'b100, 1'b0);
    checks++;
    if (phase !== 12'd1364 || corr !== 16'd2) begin
      failures++;
      $display("FAIL rev_snap_21 phase=%0d corr=%0d required 1364/2", phase, corr);
    end
    hall_step(3'b101, 1'b0);
    checks++;
    if (phase !== 12'd680 || corr !== 16'd3) begin
      failures++;
      $display("FAIL rev_snap_10 phase=%0d corr=%0d required 680/3", phase, corr);
    end
    hall_step(3'b100, 1'b0);
    pulses(30, 1'b1);
    hall_step(3'b101, 1'b1);
    checks++;
    if (phase !== 12'd678 || corr !== 16'd4) begin
      failures++;
      $display("FAIL rev_snap_pulse phase=%0d corr=%0d required 678/4", phase, corr);
    end
  endtask

  task automatic test_fault();
    hall = 3'b111;
    repeat (1023) tick();
    hall = 3'b101;
    repeat (8) tick();
    checks++;
    if (fault !== 1'b0 || valid !== 1'b1) begin
      failures++;
      $display("FAIL illegal_1023 fault=%b valid=%b required 0/1", fault, valid);
    end
    hall = 3'b111;
    repeat (1024) tick();
    hall = 3'b101;
    repeat (8) tick();
    checks++;
    if (fault !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_1024 fault=%b valid=%b required 1/0", fault, valid);
    end
    pulses(10, 1'b0);
    checks++;
    if (phase !== 12'd678) begin
      failures++;
      $display("FAIL fault_hold phase=%0d required 678", phase);
    end
    do_forecast();
    checks++;
    if (fault !== 1'b0 || phase !== 12'd342) begin
      failures++;
      $display("FAIL reinit_101 fault=%b phase=%0d required 0/342", fault, phase);
    end
    hall = 3'b110;
    tick();
    tick();
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL skip_early fault=%b required 0", fault);
    end
    tick();
    checks++;
    if (fault !== 1'b1) begin
      failures++;
      $display("FAIL skip_fault fault=%b required 1", fault);
    end
    hall = 3'b010;
    tick();
    tick();
    tick();
    do_forecast();
    checks++;
    if (phase !== 12'd2390 || fault !== 1'b0 || aligned !== 1'b0) begin
      failures++;
      $display("FAIL reinit_010 phase=%0d fault=%b aligned=%b required 2390/0/0", phase, fault, aligned);
    end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    pulse = 1'b1;
    forecast = 1'b1;
    tick();
    pulse = 1'b0;
    forecast = 1'b0;
    checks++;
    if (phase !== 12'd0 || corr !== 16'd0 || sin_v !== 16'sd0 || cos_v !== 16'sd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid phase=%0d corr=%0d sin=%0d cos=%0d valid=%b required all 0",
               phase, corr, sin_v, cos_v, valid);
    end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_init();
    test_snap();
    test_wrap();
    test_reverse();
    test_fault();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
